// File: rtl/bouncing_ball_pattern.sv
// Bouncing-ball screensaver pattern: square ball reflecting off the active-area edges,
// moved only on the vertical-blanking frame tick. Optional macro COLOR_CYCLE_EN enables palette cycling.
module bouncing_ball_pattern #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          BALL_SIZE  = 20,
    parameter int          STEP       = 1,
    parameter int          FRAME_DIV  = 1,
    parameter int          START_X    = 100,
    parameter int          START_Y    = 100,
    parameter logic [11:0] BALL_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic       clock25MHz,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       bounce
);

    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [10:0] SIZE11 = 11'(BALL_SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam int          CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    typedef struct packed {
        logic       refl;
        logic       neg;
        logic [9:0] pos;
    } axis_t;

    // One axis of motion in 11-bit arithmetic; a reflection clamps exactly to the edge.
    function automatic axis_t axis_step(input logic [9:0] pos, input logic neg,
                                        input logic [10:0] lim);
        axis_t      r;
        logic [10:0] p;
        p      = {1'b0, pos};
        r.refl = 1'b0;
        r.neg  = neg;
        r.pos  = pos;
        if (!neg) begin
            if (p + SIZE11 + STEP11 > lim) begin
                r.pos  = 10'(lim - SIZE11);
                r.neg  = 1'b1;
                r.refl = 1'b1;
            end else begin
                r.pos = 10'(p + STEP11);
            end
        end else begin
            if (p < STEP11) begin
                r.pos  = 10'd0;
                r.neg  = 1'b0;
                r.refl = 1'b1;
            end else begin
                r.pos = 10'(p - STEP11);
            end
        end
        return r;
    endfunction

    logic [9:0]       ball_x, ball_y;
    logic             neg_x, neg_y;
    logic [CNT_W-1:0] frame_cnt;
    logic             vb_seen_p0;
    logic             at_vb, frame_tick, update, refl_any;
    axis_t            nxt_x, nxt_y;
    logic [11:0]      ball_rgb;

    assign at_vb      = (x == 10'd0) && ({1'b0, y} == V_LIM);
    assign frame_tick = at_vb && !vb_seen_p0;
    assign update     = frame_tick && enable && (frame_cnt == CNT_LAST);
    assign nxt_x      = axis_step(ball_x, neg_x, H_LIM);
    assign nxt_y      = axis_step(ball_y, neg_y, V_LIM);
    assign refl_any   = nxt_x.refl || nxt_y.refl;

    always_ff @(posedge clock25MHz or negedge reset) begin
        if (!reset) begin
            ball_x     <= 10'(START_X);
            ball_y     <= 10'(START_Y);
            neg_x      <= 1'b0;
            neg_y      <= 1'b0;
            frame_cnt  <= '0;
            vb_seen_p0 <= 1'b0;
            bounce     <= 1'b0;
        end else begin
            vb_seen_p0 <= at_vb;
            bounce     <= update && refl_any;
            if (frame_tick && enable)
                frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_W'(1);
            if (update) begin
                ball_x <= nxt_x.pos;
                neg_x  <= nxt_x.neg;
                ball_y <= nxt_y.pos;
                neg_y  <= nxt_y.neg;
            end
        end
    end

`ifdef COLOR_CYCLE_EN
    logic [2:0] colour_idx;

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hF00;
            3'd2:    return 12'h0F0;
            3'd3:    return 12'h00F;
            3'd4:    return 12'hFF0;
            3'd5:    return 12'h0FF;
            3'd6:    return 12'hF0F;
            default: return 12'hF80;
        endcase
    endfunction

    // Advances once per reflecting update, even when both axes reflect together.
    always_ff @(posedge clock25MHz or negedge reset) begin
        if (!reset)
            colour_idx <= 3'd0;
        else if (update && refl_any)
            colour_idx <= colour_idx + 3'd1;
    end

    assign ball_rgb = palette(colour_idx);
`else
    assign ball_rgb = BALL_COLOR;
`endif

    logic        hit_p0;
    logic [11:0] rgb_p1;

    assign hit_p0 = ({1'b0, x} >= {1'b0, ball_x}) && ({1'b0, x} < {1'b0, ball_x} + SIZE11) &&
                    ({1'b0, y} >= {1'b0, ball_y}) && ({1'b0, y} < {1'b0, ball_y} + SIZE11);

    // p0 -> p1: registered pixel colour
    always_ff @(posedge clock25MHz or negedge reset) begin
        if (!reset)
            rgb_p1 <= BG_COLOR;
        else
            rgb_p1 <= hit_p0 ? ball_rgb : BG_COLOR;
    end

    assign red   = rgb_p1[11:8];
    assign green = rgb_p1[7:4];
    assign blue  = rgb_p1[3:0];

endmodule

// File: tb/tb_bouncing_ball_pattern.sv
// Scoreboard bench for bouncing_ball_pattern: four instances (default, right edge,
// corner, divided frame rate) share x/y/enable/reset; a monitor checks queued expectations.
module tb_bouncing_ball_pattern;

    localparam logic [11:0] BG    = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
`ifdef COLOR_CYCLE_EN
    localparam logic [11:0] HIT1 = 12'hF00;
`else
    localparam logic [11:0] HIT1 = 12'hFFF;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic [3:0] r [4];
    logic [3:0] g [4];
    logic [3:0] b [4];
    logic       bnc [4];

    always #5 clk = ~clk;

    bouncing_ball_pattern u0 (.clock25MHz(clk), .reset(reset), .enable(enable), .x(x), .y(y),
                              .red(r[0]), .green(g[0]), .blue(b[0]), .bounce(bnc[0]));
    bouncing_ball_pattern #(.START_X(618)) u1 (.clock25MHz(clk), .reset(reset), .enable(enable),
                              .x(x), .y(y), .red(r[1]), .green(g[1]), .blue(b[1]), .bounce(bnc[1]));
    bouncing_ball_pattern #(.START_X(620), .START_Y(460)) u2 (.clock25MHz(clk), .reset(reset),
                              .enable(enable), .x(x), .y(y), .red(r[2]), .green(g[2]), .blue(b[2]),
                              .bounce(bnc[2]));
    bouncing_ball_pattern #(.FRAME_DIV(4)) u3 (.clock25MHz(clk), .reset(reset), .enable(enable),
                              .x(x), .y(y), .red(r[3]), .green(g[3]), .blue(b[3]), .bounce(bnc[3]));

    typedef struct {
        int          dut;
        bit          is_rgb;
        logic [11:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    probe   = 0;
    int    probe_d = 0;
    int    tests   = 0;
    int    fails   = 0;

    always @(posedge clk) probe_d <= probe;

    // Monitor: outputs seen at the falling edge belong to the inputs of the previous cycle.
    always @(negedge clk) begin
        item_t       it;
        logic [11:0] act;
        for (int i = 0; i < probe_d; i++) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: monitor expected an entry, queue empty");
            end else begin
                it  = sb.pop_front();
                act = it.is_rgb ? {r[it.dut], g[it.dut], b[it.dut]} : {11'd0, bnc[it.dut]};
                if (act !== it.exp) begin
                    fails++;
                    $display("FAIL %s (u%0d): got %h, expected %h", it.name, it.dut, act, it.exp);
                end
            end
        end
    end

    task automatic start(input logic [9:0] xv, input logic [9:0] yv);
        x     = xv;
        y     = yv;
        probe = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rgb(input int d, input logic [11:0] e, input string n);
        sb.push_back('{d, 1'b1, e, n});
        probe++;
    endtask

    task automatic exp_b(input int d, input logic e, input string n);
        sb.push_back('{d, 1'b0, {11'd0, e}, n});
        probe++;
    endtask

    task automatic pix(input int d, input logic [9:0] xv, input logic [9:0] yv,
                       input logic [11:0] e, input string n);
        start(xv, yv);
        exp_rgb(d, e, n);
        step();
    endtask

    // Frame tick cycle then one cycle later: bounce must be a single-cycle pulse.
    task automatic frame(input logic b0, input logic b1, input logic b2, input logic b3,
                         input string n);
        start(10'd0, 10'd480);
        exp_b(0, b0, {n, "_b0"});
        exp_b(1, b1, {n, "_b1"});
        exp_b(2, b2, {n, "_b2"});
        exp_b(3, b3, {n, "_b3"});
        step();
        start(10'd1, 10'd480);
        for (int i = 0; i < 4; i++) exp_b(i, 1'b0, {n, "_pulse_end"});
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        start(10'd100, 10'd100);
        exp_rgb(0, BG, "rst_rgb");
        exp_b(0, 1'b0, "rst_bounce");
        step();
        reset = 1'b1;

        start(10'd100, 10'd100);
        exp_rgb(0, WHITE, "t1_ball_100_100");
        exp_b(0, 1'b0, "t1_bounce");
        step();
        pix(0, 10'd99, 10'd100, BG, "t1_bg_99_100");

        enable = 1'b1;
        frame(1'b0, 1'b0, 1'b1, 1'b0, "f1");
        pix(2, 10'd620, 10'd460, HIT1, "t4_corner_colour");
        pix(2, 10'd619, 10'd460, BG, "t4_left_of_ball");
        pix(2, 10'd620, 10'd459, BG, "t4_above_ball");
        pix(1, 10'd619, 10'd101, WHITE, "t3_f1_x619");
        pix(1, 10'd618, 10'd101, BG, "t3_f1_left");
        frame(1'b0, 1'b0, 1'b0, 1'b0, "f2");
        pix(2, 10'd619, 10'd459, HIT1, "t4_moved_back");
        pix(2, 10'd639, 10'd459, BG, "t4_right_clear");
        pix(1, 10'd620, 10'd102, WHITE, "t3_f2_x620");
        pix(1, 10'd619, 10'd102, BG, "t3_f2_left");
        frame(1'b0, 1'b1, 1'b0, 1'b0, "f3");
        pix(0, 10'd122, 10'd122, WHITE, "t2_corner_in");
        pix(0, 10'd123, 10'd122, BG, "t2_corner_out");
        pix(0, 10'd103, 10'd103, WHITE, "t2_topleft");
        pix(0, 10'd102, 10'd103, BG, "t2_topleft_out");
        pix(1, 10'd620, 10'd103, HIT1, "t3_clamped_620");
        pix(3, 10'd100, 10'd100, WHITE, "t5_not_updated");
        frame(1'b0, 1'b0, 1'b0, 1'b0, "f4");
        pix(1, 10'd619, 10'd104, HIT1, "t3_back_619");
        pix(1, 10'd639, 10'd104, BG, "t3_edge_clear");
        pix(3, 10'd101, 10'd101, WHITE, "t5_update1");
        pix(3, 10'd100, 10'd101, BG, "t5_update1_out");
        for (int f = 5; f <= 8; f++) frame(1'b0, 1'b0, 1'b0, 1'b0, "f5_8");
        pix(3, 10'd102, 10'd102, WHITE, "t5_update2");
        pix(3, 10'd101, 10'd102, BG, "t5_update2_out");
        pix(0, 10'd108, 10'd108, WHITE, "t2_after8");

        enable = 1'b0;
        for (int f = 0; f < 5; f++) frame(1'b0, 1'b0, 1'b0, 1'b0, "frozen");
        pix(3, 10'd102, 10'd102, WHITE, "t5_frozen_drawn");
        pix(3, 10'd101, 10'd102, BG, "t5_frozen_out");
        pix(0, 10'd108, 10'd108, WHITE, "t5_u0_frozen");
        pix(0, 10'd107, 10'd108, BG, "t5_u0_frozen_out");

        enable = 1'b1;
        for (int f = 0; f < 3; f++) frame(1'b0, 1'b0, 1'b0, 1'b0, "resume");
        pix(3, 10'd102, 10'd102, WHITE, "t5_cnt_held");
        pix(3, 10'd101, 10'd102, BG, "t5_cnt_held_out");
        frame(1'b0, 1'b0, 1'b0, 1'b0, "resume4");
        pix(3, 10'd103, 10'd103, WHITE, "t5_update3");
        pix(3, 10'd102, 10'd103, BG, "t5_update3_out");

        // Mid-cycle reset on an update cycle: outputs must clear without waiting for a clock.
        start(10'd115, 10'd115);
        step();
        start(10'd0, 10'd480);
        exp_rgb(0, BG, "t6_rgb_in_reset");
        exp_b(2, 1'b0, "t6_bounce_in_reset");
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({r[0], g[0], b[0]} !== BG) begin
            fails++;
            $display("FAIL t6_async_rgb: got %h, expected %h", {r[0], g[0], b[0]}, BG);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        start(10'd100, 10'd100);
        exp_rgb(0, WHITE, "t6_back_to_start");
        exp_b(2, 1'b0, "t6_no_bounce_after");
        step();
        pix(0, 10'd99, 10'd100, BG, "t6_start_out");

        // Reset during a tick that would reflect u2: the reflection must be discarded.
        start(10'd0, 10'd480);
        exp_b(2, 1'b0, "t6_suppressed");
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        start(10'd1, 10'd480);
        exp_b(2, 1'b0, "t6_suppressed_next");
        step();
        pix(2, 10'd620, 10'd460, WHITE, "t6_colour_reset");
        frame(1'b0, 1'b0, 1'b1, 1'b0, "t6_resume");
        pix(0, 10'd101, 10'd101, WHITE, "t6_u0_moved");
        pix(0, 10'd100, 10'd101, BG, "t6_u0_moved_out");
        pix(2, 10'd620, 10'd460, HIT1, "t6_u2_bounced");

        start(10'd0, 10'd0);
        step();
        step();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
